// File: rtl/cla_sub64_seq.sv
// cla_sub64_seq -- sequential 64-bit subtractor, one 16-bit slice per cycle.
//
// Computes diff = a - b - bin (mod 2^64) as a + ~b + ~bin, processing four
// 16-bit slices over four BUSY cycles. Each slice uses 4-bit
// borrow-lookahead groups plus slice-level lookahead across the four groups.
// The borrow out of each slice is registered and feeds the next slice.
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand set a/b/bin present
//   in_ready   block can accept an operand set this cycle
//   a, b       64-bit minuend / subtrahend
//   bin        borrow in
//   out_valid  diff/bout/zero/ovf valid
//   out_ready  consumer takes the result this cycle
//   diff       a - b - bin
//   bout       borrow out (unsigned a < b + bin)
//   zero, ovf  result flags
//
// Configuration macro CLA_SUB64_FLAGS_EN: when defined, zero and ovf are
// computed and registered together with diff. When undefined, both ports
// are tied to 0 and the flag logic is absent.
//
// state | meaning
// IDLE  | waiting for an operand set
// BUSY  | computing slice r_k (0..3), one per cycle
// DONE  | result held until out_ready

module cla_sub64_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        bin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] diff,
  output logic        bout,
  output logic        zero,
  output logic        ovf
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      r_state;
  logic [63:0] r_a;
  logic [63:0] r_b;
  logic        r_brw;
  logic [1:0]  r_k;
  logic [63:0] r_diff;
  logic        r_bout;

  logic [15:0] w_x;
  logic [15:0] w_y;
  logic [15:0] w_g;
  logic [15:0] w_p;
  logic [3:0]  w_gg;
  logic [3:0]  w_gp;
  logic [4:0]  w_gc;
  logic [15:0] w_c;
  logic [15:0] w_sdiff;
  logic        w_sbout;
  logic        w_accept;

  // Fully expanded 4-bit lookahead: returns carries {c4,c3,c2,c1,c0}.
  function automatic logic [4:0] cla4(input logic [3:0] g, input logic [3:0] p,
                                      input logic c0);
    logic [4:0] c;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | ((&p) & c0);
    return c;
  endfunction

  function automatic logic grp_gen(input logic [3:0] g, input logic [3:0] p);
    logic [4:0] c;
    c = cla4(g, p, 1'b0);
    return c[4];
  endfunction

  function automatic logic [3:0] bit_carries(input logic [3:0] g, input logic [3:0] p,
                                             input logic cin);
    logic [4:0] c;
    c = cla4(g, p, cin);
    return c[3:0];
  endfunction

  // Subtraction as addition of the inverted subtrahend; carry = ~borrow.
  always_comb begin
    w_x = r_a[{r_k, 4'b0000} +: 16];
    w_y = ~r_b[{r_k, 4'b0000} +: 16];
    w_g = w_x & w_y;
    w_p = w_x ^ w_y;
    for (int j = 0; j < 4; j++) begin
      w_gg[j] = grp_gen(w_g[4*j +: 4], w_p[4*j +: 4]);
      w_gp[j] = &w_p[4*j +: 4];
    end
    w_gc = cla4(w_gg, w_gp, ~r_brw);
    for (int j = 0; j < 4; j++) begin
      w_c[4*j +: 4] = bit_carries(w_g[4*j +: 4], w_p[4*j +: 4], w_gc[j]);
    end
    w_sdiff = w_p ^ w_c;
    w_sbout = ~w_gc[4];
  end

  assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign out_valid = (r_state == DONE);
  assign w_accept  = in_valid && in_ready;
  assign diff      = r_diff;
  assign bout      = r_bout;

`ifdef CLA_SUB64_FLAGS_EN
  logic r_zero;
  logic r_ovf;
  assign zero = r_zero;
  assign ovf  = r_ovf;
`else
  assign zero = 1'b0;
  assign ovf  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_brw   <= 1'b0;
      r_k     <= 2'd0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
`ifdef CLA_SUB64_FLAGS_EN
      r_zero  <= 1'b0;
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_brw   <= bin;
            r_k     <= 2'd0;
            r_state <= BUSY;
          end else if (r_state == DONE && out_ready) begin
            r_state <= IDLE;
          end
        end
        BUSY: begin
          r_diff[{r_k, 4'b0000} +: 16] <= w_sdiff;
          r_brw <= w_sbout;
          r_k   <= r_k + 2'd1;
          if (r_k == 2'd3) begin
            r_bout  <= w_sbout;
            r_state <= DONE;
`ifdef CLA_SUB64_FLAGS_EN
            // Slice 3 is still in flight, so combine it with the stored low slices.
            r_zero <= (r_diff[47:0] == 48'd0) && (w_sdiff == 16'd0);
            r_ovf  <= (r_a[63] != r_b[63]) && (w_sdiff[15] != r_a[63]);
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_sub64_seq.sv
// Directed testbench for cla_sub64_seq: hand-computed vectors, latency,
// backpressure, back-to-back accept and mid-operation reset.

module tb_cla_sub64_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] a_i = '0;
  logic [63:0] b_i = '0;
  logic        bin_i = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] diff;
  logic        bout;
  logic        zero;
  logic        ovf;

  int n_vec = 0;
  int n_err = 0;

  cla_sub64_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_i),
    .b         (b_i),
    .bin       (bin_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .zero      (zero),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  // Flags only exist when the feature macro is defined; otherwise they read 0.
  function automatic logic flag(input logic v);
`ifdef CLA_SUB64_FLAGS_EN
    return v;
`else
    return 1'b0;
`endif
  endfunction

  task automatic scramble();
    a_i   = ~a_i;
    b_i   = {$urandom, $urandom};
    bin_i = ~bin_i;
  endtask

  // Present operands at negedge, accept on next posedge, then scramble inputs.
  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic bi);
    @(negedge clk);
    a_i = a; b_i = b; bin_i = bi; in_valid = 1'b1;
    #1;
    chk("in_ready_at_accept", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    scramble();
  endtask

  task automatic wait_done();
    int lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 20);
    chk("latency", 64'(lat), 64'd4);
  endtask

  task automatic chk_res(input string tag, input logic [63:0] ed, input logic eb,
                         input logic ez, input logic eo);
    chk({tag, "_diff"}, diff, ed);
    chk({tag, "_bout"}, bout, eb);
    chk({tag, "_zero"}, zero, flag(ez));
    chk({tag, "_ovf"},  ovf,  flag(eo));
  endtask

  task automatic retire();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("retire_out_valid", out_valid, 1'b0);
    chk("retire_in_ready", in_ready, 1'b1);
  endtask

  task automatic run(input string tag, input logic [63:0] a, input logic [63:0] b,
                     input logic bi, input logic [63:0] ed, input logic eb,
                     input logic ez, input logic eo);
    send(a, b, bi);
    wait_done();
    chk_res(tag, ed, eb, ez, eo);
    retire();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] held;
    logic        seen;

    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_diff", diff, 64'd0);
    chk("rst_bout", bout, 1'b0);
    chk("rst_zero", zero, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);

    run("sub5_3",   64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0, 1'b0);
    run("zero_m1",  64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
    run("eq_bin1",  64'h1234, 64'h1234, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
    run("eq_bin0",  64'h1234, 64'h1234, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
    run("xslice1",  64'h0000_0000_0001_0000, 64'd1, 1'b0, 64'h0000_0000_0000_FFFF, 1'b0, 1'b0, 1'b0);
    run("xslice3",  64'h0001_0000_0000_0000, 64'd1, 1'b0, 64'h0000_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
    run("ovf_min",  64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1);
    run("wrap_all", 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'd0, 1'b1, 1'b1, 1'b0);

    // Backpressure: hold result for 10 cycles, then retire and accept together.
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF, 1'b1);
    wait_done();
    chk_res("bp", 64'hFEDC_BA98_7654_320F, 1'b0, 1'b0, 1'b0);
    held = diff;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      scramble();
      @(posedge clk);
      #1;
      chk("bp_hold_diff", diff, held);
      chk("bp_hold_valid", out_valid, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    @(negedge clk);
    a_i = 64'h100; b_i = 64'd1; bin_i = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b0;
    scramble();
    chk("b2b_busy", out_valid, 1'b0);
    wait_done();
    chk_res("b2b", 64'hFF, 1'b0, 1'b0, 1'b0);
    retire();

    // Reset in the second BUSY cycle discards the operation.
    send(64'd9, 64'd4, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_diff", diff, 64'd0);
    chk("midrst_bout", bout, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("midrst_no_stale", seen, 1'b0);

    run("post_rst", 64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cla_sub64_seq.md
CLA_SUB64_SEQ -- requirements
Module: cla_sub64_seq

Interface
REQ-001 Parameters: none; width fixed at 64 bits, 4 slices of 16 bits, 4-bit borrow-lookahead groups.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operand set a/b/bin present.
REQ-005 in_ready  output  1  block can accept an operand set this cycle.
REQ-006 a  input  64  minuend.
REQ-007 b  input  64  subtrahend.
REQ-008 bin  input  1  borrow in.
REQ-009 out_valid  output  1  diff/bout/flags valid.
REQ-010 out_ready  input  1  consumer takes result this cycle.
REQ-011 diff  output  64  a - b - bin, modulo 2^64.
REQ-012 bout  output  1  borrow out; 1 when unsigned a < b + bin.
REQ-013 zero  output  1  diff == 0 (see REQ-030).
REQ-014 ovf  output  1  two's-complement signed overflow (see REQ-030).

Function
REQ-015 FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-016 in_ready = (state==IDLE) or (state==DONE and out_ready); out_valid = (state==DONE).
REQ-017 Accept = in_valid and in_ready; on accept, a, b, bin captured into internal registers, slice counter cleared to 0, state -> BUSY.
REQ-018 Operand inputs ignored outside an accept cycle; changes during BUSY/DONE do not affect result.
REQ-019 BUSY: each cycle computes one 16-bit slice k (bits 16k+15:16k), k=0..3, as a + ~b + carry, carry = ~borrow; slice borrow from 4 lookahead groups (group G/P, then slice-level lookahead), no ripple between bits.
REQ-020 Slice 0 borrow-in = captured bin; slice k>0 borrow-in = registered borrow-out of slice k-1.
REQ-021 After slice 3 completes, bout = slice-3 borrow-out; state -> DONE.
REQ-022 Latency: accept at edge N; out_valid high from edge N+4; result available 4 cycles after accept.
REQ-023 DONE holds diff, bout, zero, ovf stable while out_ready=0, indefinitely.
REQ-024 DONE with out_ready=1 and in_valid=0: state -> IDLE.
REQ-025 DONE with out_ready=1 and in_valid=1: result retired and new operands accepted on the same edge, state -> BUSY (back-to-back, 5-cycle period).
REQ-026 out_ready ignored outside DONE; in_valid ignored in BUSY.

Reset
REQ-027 rst_n low: state IDLE, slice counter 0, diff 0, bout 0, zero 0, ovf 0, out_valid 0, in_ready 1 (after release); effect immediate, no clock required.
REQ-028 Reset during BUSY or DONE discards the in-flight operation; no result emitted after release.
REQ-029 First accept possible on first rising edge with rst_n high.

Configuration
REQ-030 Macro CLA_SUB64_FLAGS_EN: defined -> zero = (diff==0), ovf = (a[63] != b[63]) and (diff[63] != a[63]) using captured operands, both registered at DONE entry with diff; undefined -> zero and ovf tied 0, flag logic absent, ports retained.

Verification
REQ-031 a=5, b=3, bin=0 -> diff=2, bout=0, zero=0, ovf=0; out_valid exactly 4 cycles after accept.
REQ-032 a=0, b=1, bin=0 -> diff=0xFFFF_FFFF_FFFF_FFFF, bout=1; a=b=0x1234, bin=1 -> same diff, bout=1; a=b=0x1234, bin=0 -> diff=0, zero=1 (macro defined).
REQ-033 Cross-slice borrow: a=0x0000_0000_0001_0000, b=0x1 -> diff=0x0000_0000_0000_FFFF, bout=0; a=0x0001_0000_0000_0000, b=0x1 -> diff=0x0000_FFFF_FFFF_FFFF.
REQ-034 Overflow: a=0x8000_0000_0000_0000, b=1 -> diff=0x7FFF_FFFF_FFFF_FFFF, ovf=1 with macro, ovf=0 without.
REQ-035 Backpressure: out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0; then out_ready=1 with in_valid=1 -> new accept same edge, next result 4 cycles later; operand changes during BUSY do not alter result.
REQ-036 rst_n low in 2nd BUSY cycle -> out_valid=0 immediately, in_ready=1 after release, no stale result ever presented.
